// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding and
// stream field helpers.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLen  = 3'd1,
    StData = 3'd2,
    StCsum = 3'd3,
    StDone = 3'd4,
    StErr  = 3'd5
  } state_e;

  localparam int unsigned ByteW = 8;
  // A length byte of zero encodes a full 256-byte program.
  localparam logic [ByteW-1:0] LenFull = 8'h00;

  function automatic logic is_stream_state(input state_e s);
    return (s == StLen) || (s == StData) || (s == StCsum);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream valid/ready handshake into the program loader.
interface prog_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/prog_loader_wr_port.sv
// Registered memory write stage: one strobe per accepted program byte, one
// cycle after the accept.
module prog_loader_wr_port #(
  parameter int unsigned   AW   = 8,
  parameter logic [AW-1:0] BASE = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          accept_i,
  input  logic [AW-1:0] idx_i,
  input  logic [7:0]    byte_i,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_adr_o,
  output logic [7:0]    mem_wdata_o
);

  logic          we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [7:0]    wdata_q, wdata_d;

  always_comb begin
    we_d    = accept_i;
    adr_d   = adr_q;
    wdata_d = wdata_q;
    if (accept_i) begin
      adr_d   = BASE + idx_i;
      wdata_d = byte_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_we_o    = we_q;
  assign mem_adr_o   = adr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed, checksummed byte stream into program memory and
// holds the processor in reset until a load verifies.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned   AW   = 8,
  parameter logic [AW-1:0] BASE = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  prog_loader_if.slave  in_if,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [7:0]    mem_wdata,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [7:0]    count
);

  state_e        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    count_q, count_d;
  logic [AW-1:0] idx_q, idx_d;

  logic xfer;
  logic accept;

  assign xfer   = in_if.in_valid && is_stream_state(state_q);
  assign accept = xfer && (state_q == StData);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sum_d   = sum_q;
    count_d = count_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StLen;
          sum_d   = '0;
          count_d = '0;
          idx_d   = '0;
        end
      end
      StLen: begin
        if (xfer) begin
          len_d   = in_if.in_data;
          state_d = StData;
        end
      end
      StData: begin
        if (xfer) begin
          sum_d   = sum_q + in_if.in_data;
          count_d = count_q + 8'd1;
          idx_d   = idx_q + AW'(1);
          // 8-bit wrap makes a zero length byte terminate after 256 bytes.
          if (count_d == len_q) begin
            state_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (xfer) begin
          state_d = (in_if.in_data == sum_q) ? StDone : StErr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_if.in_ready = is_stream_state(state_q);
    busy           = is_stream_state(state_q);
    done           = (state_q == StDone);
    err            = (state_q == StErr);
    cpu_reset      = (state_q != StDone);
  end

  assign count = count_q;

  prog_loader_wr_port #(
    .AW   (AW),
    .BASE (BASE)
  ) u_wr_port (
    .clk         (clk),
    .reset       (reset),
    .accept_i    (accept),
    .idx_i       (idx_q),
    .byte_i      (in_if.in_data),
    .mem_we_o    (mem_we),
    .mem_adr_o   (mem_adr),
    .mem_wdata_o (mem_wdata)
  );

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed and random loads against a
// stream-level reference model with a write scoreboard.
module tb_prog_loader;

  localparam logic [7:0] BaseTb = 8'h00;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [7:0] adr;
    logic [7:0] dat;
    int         at;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       mem_we;
  logic [7:0] mem_adr;
  logic [7:0] mem_wdata;
  logic       cpu_reset;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] count;

  prog_loader_if sif ();

  prog_loader #(
    .AW   (8),
    .BASE (BaseTb)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_if     (sif),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .count     (count)
  );

  always #5 clk = ~clk;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  bit  mon_en  = 1'b0;
  wr_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every strobe must match the oldest outstanding expected write, on time.
  always @(negedge clk) begin
    if (mon_en && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", 32'd1, 32'd0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_adr", {24'd0, mem_adr}, {24'd0, w.adr});
        check("wr_data", {24'd0, mem_wdata}, {24'd0, w.dat});
        check("wr_cycle", cyc, w.at);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      sif.in_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic xfer(input logic [7:0] b, input bit is_data, input logic [7:0] adr);
    int n = 0;
    sif.in_valid = 1'b1;
    sif.in_data  = b;
    @(negedge clk);
    while (!sif.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!sif.in_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      sif.in_valid = 1'b0;
      return;
    end
    if (is_data) exp_q.push_back('{adr, b, cyc + 1});
    @(posedge clk);
    #1;
    sif.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("start_done", {31'd0, done}, 32'd0);
    check("start_err", {31'd0, err}, 32'd0);
    check("start_count", {24'd0, count}, 32'd0);
  endtask

  task automatic run_load(input logic [7:0] len, input byte_q_t data, input logic [7:0] csum,
                          input int gap_max);
    logic [7:0] s = 8'd0;
    bit         pass;
    pulse_start();
    xfer(len, 1'b0, 8'd0);
    for (int i = 0; i < data.size(); i++) begin
      idle($urandom_range(0, gap_max));
      xfer(data[i], 1'b1, 8'(BaseTb + 8'(i)));
      s = s + data[i];
      check("count", {24'd0, count}, (i + 1) % 256);
    end
    check("pre_csum_done", {31'd0, done}, 32'd0);
    check("pre_csum_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    idle($urandom_range(0, gap_max));
    pass = (csum == s);
    xfer(csum, 1'b0, 8'd0);
    check("done", {31'd0, done}, {31'd0, pass});
    check("err", {31'd0, err}, {31'd0, !pass});
    check("cpu_reset", {31'd0, cpu_reset}, {31'd0, !pass});
    check("busy_end", {31'd0, busy}, 32'd0);
    check("ready_end", {31'd0, sif.in_ready}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    byte_q_t q;
    logic [7:0] s;
    sif.in_valid = 1'b0;
    sif.in_data  = 8'd0;
    start        = 1'b0;
    reset        = 1'b0;

    // 1: reset state
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_in_ready", {31'd0, sif.in_ready}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_count", {24'd0, count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;

    // Bytes offered while idle must be ignored.
    sif.in_valid = 1'b1;
    idle(3);
    sif.in_valid = 1'b0;
    check("idle_count", {24'd0, count}, 32'd0);

    // 2: good load
    q = '{8'h20, 8'h8C, 8'h01};
    run_load(8'h03, q, 8'hAD, 0);
    check("t2_count", {24'd0, count}, 32'd3);

    // Bytes offered in DONE are ignored and the outputs hold.
    sif.in_valid = 1'b1;
    idle(3);
    sif.in_valid = 1'b0;
    check("done_hold", {31'd0, done}, 32'd1);
    check("done_hold_count", {24'd0, count}, 32'd3);

    // 3: bad checksum, then a retry that passes
    q = '{8'h10, 8'h20};
    run_load(8'h02, q, 8'h31, 0);
    run_load(8'h02, q, 8'h30, 0);

    // 4: full 256-byte load, address wrap
    q = {};
    for (int i = 0; i < 256; i++) q.push_back(8'(i));
    run_load(8'h00, q, 8'h80, 0);
    check("t4_count_wrap", {24'd0, count}, 32'd0);
    check("t4_done", {31'd0, done}, 32'd1);

    // 5: random loads with random handshake gaps
    for (int t = 0; t < 8; t++) begin
      int n;
      n = (t == 0) ? 5 : $urandom_range(1, 9);
      q = {};
      s = 8'd0;
      for (int i = 0; i < n; i++) begin
        q.push_back(8'($urandom));
        s = s + q[i];
      end
      if ($urandom_range(0, 3) == 0) s = s ^ 8'($urandom_range(1, 255));
      run_load(8'(n), q, s, 3);
    end

    // 6: reset mid-DATA after 2 of 4 bytes; start mid-DATA is ignored
    pulse_start();
    xfer(8'h04, 1'b0, 8'd0);
    xfer(8'h11, 1'b1, 8'(BaseTb));
    xfer(8'h22, 1'b1, 8'(BaseTb + 8'd1));
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("t6_busy_after_start", {31'd0, busy}, 32'd1);
    check("t6_count_after_start", {24'd0, count}, 32'd2);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t6_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("t6_ready", {31'd0, sif.in_ready}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_count", {24'd0, count}, 32'd0);
    check("t6_mem_we", {31'd0, mem_we}, 32'd0);
    reset = 1'b1;
    sif.in_valid = 1'b1;
    idle(3);
    sif.in_valid = 1'b0;
    idle(2);
    check("pending_writes", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
